// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, constants and fetch-entry type for the fetch path
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    // One prefetch queue slot: the instruction together with the address it came from.
    typedef struct packed {
        logic [INSTR_W-1:0] pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush, used as the prefetch queue
module fetch_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [CNT_W-1:0]  count,
    output logic              full
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              empty;
    logic              do_push;
    logic              do_pop;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // Flush wins over everything; a pop frees the slot a same-cycle push needs when full.
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;

    assign rdata = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_queue_ctrl.sv
// rtl/fetch_queue_ctrl.sv - PC sequencing, range check and redirect handling around the prefetch queue
module fetch_queue_ctrl
    import mips_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter int               QDEPTH     = 4,
    parameter int               IMEM_WORDS = 100,
    parameter logic [WIDTH-1:0] RESET_PC   = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rd,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             ins_valid,
    output logic [WIDTH-1:0] ins_data,
    output logic [WIDTH-1:0] ins_pc,
    input  logic             ins_ready,
    output logic             fetch_halted
);

    localparam int ENTRY_W = 2 * WIDTH;
    localparam int CNT_W   = $clog2(QDEPTH + 1);

    logic [WIDTH-1:0]   pc;
    logic               in_range;
    logic               pop;
    logic               push;
    logic [ENTRY_W-1:0] head;
    logic [CNT_W-1:0]   count;
    logic               q_full;
    logic               unused_low_bits;

    // The low two redirect bits are dropped: fetch is always word aligned.
    assign unused_low_bits = ^redirect_pc[1:0];

    assign imem_addr    = pc;
    assign in_range     = (pc >> 2) < WIDTH'(IMEM_WORDS);
    assign fetch_halted = ~in_range;

    // A redirect discards the queue, so the head it would have consumed is not popped.
    assign pop  = ins_valid & ins_ready;
    assign push = in_range & (~q_full | pop) & ~redirect_valid;

    // Program counter: redirect beats sequential advance; holds while stalled or halted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= {redirect_pc[WIDTH-1:2], 2'b00};
        end else if (push) begin
            pc <= pc + WIDTH'(PC_STEP);
        end
    end

    fetch_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop & ~redirect_valid),
        .wdata ({pc, imem_rd}),
        .rdata (head),
        .count (count),
        .full  (q_full)
    );

    // Head presentation; stale storage is masked to zeros whenever the queue is empty.
    always_comb begin
        ins_valid = (count != '0);
        ins_pc    = '0;
        ins_data  = WIDTH'(NOP_INSTR);
        if (ins_valid) begin
            ins_pc   = head[ENTRY_W-1:WIDTH];
            ins_data = head[WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// tb/tb_fetch_queue_ctrl.sv - directed checks of fetch, stall, redirect, halt and async reset
module tb_fetch_queue_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ins_valid;
    logic [31:0] ins_data;
    logic [31:0] ins_pc;
    logic        ins_ready;
    logic        fetch_halted;

    int checks = 0;
    int errors = 0;

    fetch_queue_ctrl #(
        .WIDTH      (32),
        .QDEPTH     (4),
        .IMEM_WORDS (100),
        .RESET_PC   (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rd        (imem_rd),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ins_valid      (ins_valid),
        .ins_data       (ins_data),
        .ins_pc         (ins_pc),
        .ins_ready      (ins_ready),
        .fetch_halted   (fetch_halted)
    );

    // ROM word i holds i + 0x100.
    assign imem_rd = (imem_addr >> 2) + 32'h100;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic rdy);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        ins_ready      = rdy;
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        ins_ready      = 1'b1;
        #3;
        check("rst_valid", 32'(ins_valid), 32'd0);
        check("rst_data", ins_data, 32'h0);
        check("rst_pc", ins_pc, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_halted", 32'(fetch_halted), 32'd0);

        // Streaming with decode always ready: one instruction per cycle from E0.
        apply_reset(1'b1);
        for (int i = 0; i < 6; i++) begin
            step();
            check("stream_valid", 32'(ins_valid), 32'd1);
            check("stream_pc", ins_pc, 32'(4 * i));
            check("stream_data", ins_data, 32'h100 + 32'(i));
        end

        // Decode stalled: queue fills in four cycles, PC freezes at 0x10.
        apply_reset(1'b0);
        for (int k = 0; k < 8; k++) begin
            step();
            check("stall_addr", imem_addr, (k < 3) ? 32'(4 * (k + 1)) : 32'h10);
            check("stall_head", ins_pc, 32'h0);
        end
        check("stall_valid", 32'(ins_valid), 32'd1);
        check("stall_data", ins_data, 32'h100);
        // Release: full queue pops and pushes together, no bubble, no loss.
        ins_ready = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            step();
            check("drain_pc", ins_pc, 32'(4 * j));
            check("drain_data", ins_data, 32'h100 + 32'(j));
            check("drain_addr", imem_addr, 32'h10 + 32'(4 * j));
        end

        // Redirect to 0x22 with three queued entries and decode ready.
        apply_reset(1'b0);
        step();
        step();
        step();
        check("redir_pre_addr", imem_addr, 32'hC);
        ins_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h22;
        step();
        redirect_valid = 1'b0;
        check("redir_valid0", 32'(ins_valid), 32'd0);
        check("redir_data0", ins_data, 32'h0);
        check("redir_pc0", ins_pc, 32'h0);
        check("redir_addr", imem_addr, 32'h20);
        step();
        check("redir_valid1", 32'(ins_valid), 32'd1);
        check("redir_pc1", ins_pc, 32'h20);
        check("redir_data1", ins_data, 32'h108);
        step();
        check("redir_pc2", ins_pc, 32'h24);
        check("redir_data2", ins_data, 32'h109);

        // End of instruction memory: word 99 is the last fetched, then halt.
        apply_reset(1'b1);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h184;
        step();
        redirect_valid = 1'b0;
        check("end_bubble", 32'(ins_valid), 32'd0);
        check("end_addr0", imem_addr, 32'h184);
        step();
        check("end_pc97", ins_pc, 32'h184);
        check("end_data97", ins_data, 32'h161);
        check("end_nohalt", 32'(fetch_halted), 32'd0);
        step();
        check("end_pc98", ins_pc, 32'h188);
        check("end_data98", ins_data, 32'h162);
        step();
        check("end_pc99", ins_pc, 32'h18C);
        check("end_data99", ins_data, 32'h163);
        check("end_halted", 32'(fetch_halted), 32'd1);
        check("end_addr1", imem_addr, 32'h190);
        step();
        check("end_drained", 32'(ins_valid), 32'd0);
        check("end_halt_hold", 32'(fetch_halted), 32'd1);
        step();
        check("end_addr_hold", imem_addr, 32'h190);
        check("end_still_empty", 32'(ins_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        step();
        redirect_valid = 1'b0;
        check("unhalt", 32'(fetch_halted), 32'd0);
        check("unhalt_addr", imem_addr, 32'h0);
        step();
        check("unhalt_valid", 32'(ins_valid), 32'd1);
        check("unhalt_pc", ins_pc, 32'h0);
        check("unhalt_data", ins_data, 32'h100);

        // Asynchronous reset with a full queue, between clock edges.
        apply_reset(1'b0);
        for (int k = 0; k < 5; k++) begin
            step();
        end
        check("full_valid", 32'(ins_valid), 32'd1);
        check("full_addr", imem_addr, 32'h10);
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(ins_valid), 32'd0);
        check("arst_data", ins_data, 32'h0);
        check("arst_pc", ins_pc, 32'h0);
        check("arst_addr", imem_addr, 32'h0);
        rst = 1'b0;
        step();
        check("arst_refill", 32'(ins_valid), 32'd1);
        check("arst_refill_data", ins_data, 32'h100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
